// File: rtl/alarm_pkg.sv
// Shared constants for the alarm-clock set path: modes, cursor codes,
// time-word field positions, field limits and the controller state type.
package alarm_pkg;

    localparam logic [1:0] MODE_RUN       = 2'b00;
    localparam logic [1:0] MODE_SET_CLOCK = 2'b10;
    localparam logic [1:0] MODE_SET_ALARM = 2'b11;

    localparam logic [1:0] CUR_DAY       = 2'b00;
    localparam logic [1:0] CUR_HOUR      = 2'b01;
    localparam logic [1:0] CUR_MIN_TENS  = 2'b10;
    localparam logic [1:0] CUR_MIN_UNITS = 2'b11;

    // Time word layout: {PM, day[2:0], hour[3:0], min tens[3:0], min units[3:0]}
    localparam int PM_BIT   = 15;
    localparam int DAY_HI   = 14;
    localparam int DAY_LO   = 12;
    localparam int HOUR_HI  = 11;
    localparam int HOUR_LO  = 8;
    localparam int TENS_HI  = 7;
    localparam int TENS_LO  = 4;
    localparam int UNITS_HI = 3;
    localparam int UNITS_LO = 0;

    localparam logic [15:0] RESET_TIME = 16'h0100;

    localparam logic [2:0] DAY_MAX      = 3'd6;
    localparam logic [3:0] HOUR_MIN     = 4'd1;
    localparam logic [3:0] HOUR_MAX     = 4'd12;
    localparam logic [3:0] HOUR_PM_EDGE = 4'd11;
    localparam logic [3:0] TENS_MAX     = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_CLOCK = 2'd1,
        ST_COMMIT    = 2'd2,
        ST_SET_ALARM = 2'd3
    } ctrl_state_t;

    // COMMIT still shows SET_CLOCK: the display keeps the edited clock time
    // on screen during the load cycle.
    function automatic logic [1:0] mode_of(input ctrl_state_t st);
        case (st)
            ST_SET_CLOCK, ST_COMMIT: mode_of = MODE_SET_CLOCK;
            ST_SET_ALARM:            mode_of = MODE_SET_ALARM;
            default:                 mode_of = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/time_field_inc.sv
// Combinational single-field increment of a packed time word.
// Wraps each field in range and forces out-of-range values to the field minimum.
module time_field_inc
    import alarm_pkg::*;
(
    input  logic [15:0] time_in,
    input  logic [1:0]  cursor,
    output logic [15:0] time_out
);

    logic [2:0] day;
    logic [3:0] hour;
    logic [3:0] tens;
    logic [3:0] units;

    always_comb begin
        day   = time_in[DAY_HI:DAY_LO];
        hour  = time_in[HOUR_HI:HOUR_LO];
        tens  = time_in[TENS_HI:TENS_LO];
        units = time_in[UNITS_HI:UNITS_LO];
        time_out = time_in;
        case (cursor)
            CUR_DAY: begin
                time_out[DAY_HI:DAY_LO] = (day >= DAY_MAX) ? 3'd0 : day + 3'd1;
            end
            CUR_HOUR: begin
                // 11 -> 12 is the noon/midnight crossing, so PM flips there.
                if (hour == HOUR_PM_EDGE) begin
                    time_out[HOUR_HI:HOUR_LO] = HOUR_MAX;
                    time_out[PM_BIT]          = ~time_in[PM_BIT];
                end else if (hour >= HOUR_MIN && hour < HOUR_MAX) begin
                    time_out[HOUR_HI:HOUR_LO] = hour + 4'd1;
                end else begin
                    time_out[HOUR_HI:HOUR_LO] = HOUR_MIN;
                end
            end
            CUR_MIN_TENS: begin
                time_out[TENS_HI:TENS_LO] = (tens >= TENS_MAX) ? 4'd0 : tens + 4'd1;
            end
            default: begin
                time_out[UNITS_HI:UNITS_LO] = (units >= UNITS_MAX) ? 4'd0 : units + 4'd1;
            end
        endcase
    end

endmodule

// File: rtl/set_mode_controller.sv
// Set-mode sequencer: turns button pulses into display mode, cursor and the
// edit buffer, owns the alarm register and issues the clock-load pulse.
module set_mode_controller
    import alarm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16'd60000,
    parameter int          TW      = 16
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        BtnMode,
    input  logic        BtnNext,
    input  logic        BtnInc,
    input  logic [14:0] CT,
    input  logic        CPM,
    output logic [1:0]  S,
    output logic [1:0]  CW,
    output logic [15:0] ST,
    output logic [15:0] AT,
    output logic        ClkLoad,
    output logic [1:0]  state_dbg
);

    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    ctrl_state_t   state, state_next;
    logic [1:0]    cw_next;
    logic [15:0]   st_next, at_next, st_inc;
    logic          load_next;
    logic [TW-1:0] idle_cnt, idle_next;

    time_field_inc u_inc (
        .time_in  (ST),
        .cursor   (CW),
        .time_out (st_inc)
    );

    assign state_dbg = state;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state    <= ST_RUN;
            S        <= MODE_RUN;
            CW       <= CUR_DAY;
            ST       <= RESET_TIME;
            AT       <= RESET_TIME;
            ClkLoad  <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_next;
            S        <= mode_of(state_next);
            CW       <= cw_next;
            ST       <= st_next;
            AT       <= at_next;
            ClkLoad  <= load_next;
            idle_cnt <= idle_next;
        end
    end

    // Only one button is acted on per cycle: mode, then next, then inc.
    // The idle counter stays at zero unless a set mode sees a quiet cycle.
    always_comb begin
        state_next = state;
        cw_next    = CW;
        st_next    = ST;
        at_next    = AT;
        load_next  = 1'b0;
        idle_next  = '0;
        case (state)
            ST_RUN: begin
                if (BtnMode) begin
                    state_next = ST_SET_CLOCK;
                    st_next    = {CPM, CT};
                    cw_next    = CUR_DAY;
                end
            end
            ST_COMMIT: begin
                state_next = ST_SET_ALARM;
                st_next    = AT;
                cw_next    = CUR_DAY;
            end
            default: begin
                if (BtnMode) begin
                    if (state == ST_SET_CLOCK) begin
                        state_next = ST_COMMIT;
                        load_next  = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                        at_next    = ST;
                        cw_next    = CUR_DAY;
                    end
                end else if (BtnNext) begin
                    cw_next = CW + 2'd1;
                end else if (BtnInc) begin
                    st_next = st_inc;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_next = ST_RUN;
                    cw_next    = CUR_DAY;
                end else begin
                    idle_next = idle_cnt + TW'(1);
                end
            end
        endcase
    end

endmodule
